// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem req/ack port, 2-entry
// in-order instruction buffer toward decode, redirect and halt handling.
module instr_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              if_valid,
  output logic [31:0]       if_instr,
  output logic [ADDR_W-1:0] if_pc,
  input  logic              if_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              halted
);

  localparam logic [1:0] S_RUN     = 2'd0;
  localparam logic [1:0] S_DRAIN   = 2'd1;
  localparam logic [1:0] S_HALTING = 2'd2;
  localparam logic [1:0] S_HALTED  = 2'd3;

  localparam logic [ADDR_W-1:0] PC_MASK = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [31:0]       instr;
  } ent_t;

  logic [1:0]        state;
  logic              started;
  logic [ADDR_W-1:0] pc, hold_addr;
  logic [1:0]        count;
  logic              rd_ptr, wr_ptr;
  ent_t              fifo [2];
  ent_t              head;

  logic in_run, waiting, live, do_halt, do_redir, push, pop, flush;

  // Old request stays on the bus while draining/halting; pc already holds the new target.
  assign waiting   = (state == S_DRAIN) || (state == S_HALTING);
  assign in_run    = (state == S_RUN);
  assign imem_req  = (started && in_run && (count < 2'd2)) || waiting;
  assign imem_addr = waiting ? hold_addr : pc;

  assign live     = in_run || (state == S_DRAIN);
  assign do_halt  = halt && live;
  assign do_redir = redirect && live && !halt;
  assign flush    = do_halt || do_redir;
  assign push     = in_run && imem_req && imem_ack && !redirect && !halt;
  assign pop      = in_run && if_valid && if_ready && !redirect && !halt;

  assign head     = fifo[rd_ptr];
  assign if_valid = (count != 2'd0);
  assign if_instr = head.instr;
  assign if_pc    = head.pc;
  assign halted   = (state == S_HALTED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_RUN;
      started   <= 1'b0;
      pc        <= RESET_PC & PC_MASK;
      hold_addr <= '0;
      count     <= 2'd0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      fifo[0]   <= '0;
      fifo[1]   <= '0;
    end else begin
      started <= 1'b1;
      if (flush) begin
        count  <= 2'd0;
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
      end else begin
        if (push) begin
          fifo[wr_ptr] <= '{pc: pc, instr: imem_rdata};
          wr_ptr       <= ~wr_ptr;
        end
        if (pop) rd_ptr <= ~rd_ptr;
        count <= count + 2'(push) - 2'(pop);
      end

      if (push)          pc <= pc + PC_STEP;
      else if (do_redir) pc <= redirect_pc & PC_MASK;

      case (state)
        S_RUN: begin
          if (do_halt) begin
            state     <= (imem_req && !imem_ack) ? S_HALTING : S_HALTED;
            hold_addr <= pc;
          end else if (do_redir && imem_req && !imem_ack) begin
            state     <= S_DRAIN;
            hold_addr <= pc;
          end
        end
        S_DRAIN: begin
          if (do_halt)       state <= imem_ack ? S_HALTED : S_HALTING;
          else if (imem_ack) state <= S_RUN;
        end
        S_HALTING: if (imem_ack) state <= S_HALTED;
        default:   state <= S_HALTED;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit; memory returns word index (addr>>2).
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halt = 1'b0;
  logic        halted;

  int checks = 0;
  int errors = 0;

  instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt), .halted(halted)
  );

  always #5 clk = ~clk;
  assign imem_rdata = imem_addr >> 2;

  task automatic step();
    @(negedge clk);
  endtask

  // Leaves the bench at the negedge where the first request is visible.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; redirect = 1'b0; halt = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #3;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", if_valid); end
    checks++; if (if_instr !== 32'h0 || if_pc !== 32'h0) begin errors++; $display("FAIL reset_head: got %h/%h want 0/0", if_pc, if_instr); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", halted); end
  endtask

  task automatic test_stream();
    imem_ack = 1'b1; if_ready = 1'b1;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(4*k)) begin
        errors++; $display("FAIL stream_req[%0d]: got %b/%h want 1/%h", k, imem_req, imem_addr, 32'(4*k)); end
      if (k == 0) begin
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL stream_first_valid: got %b want 0", if_valid); end
      end else begin
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'(4*(k-1)) || if_instr !== 32'(k-1)) begin
          errors++; $display("FAIL stream_head[%0d]: got %b %h/%h want 1 %h/%h", k, if_valid, if_pc, if_instr, 32'(4*(k-1)), 32'(k-1)); end
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    imem_ack = 1'b1; if_ready = 1'b0;
    do_reset();
    step(); step();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_req_gated: got %b want 0", imem_req); end
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'h0) begin
      errors++; $display("FAIL bp_head0: got %b %h/%h want 1 0/0", if_valid, if_pc, if_instr); end
    step();
    checks++; if (imem_req !== 1'b0 || if_pc !== 32'h0) begin errors++; $display("FAIL bp_hold: got req %b pc %h want 0 0", imem_req, if_pc); end
    if_ready = 1'b1;
    step();
    checks++; if (if_pc !== 32'h4 || if_instr !== 32'h1) begin errors++; $display("FAIL bp_head1: got %h/%h want 4/1", if_pc, if_instr); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin errors++; $display("FAIL bp_resume: got %b/%h want 1/8", imem_req, imem_addr); end
    step();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h8 || if_instr !== 32'h2) begin
      errors++; $display("FAIL bp_head2: got %b %h/%h want 1 8/2", if_valid, if_pc, if_instr); end
  endtask

  task automatic test_redirect_drain();
    imem_ack = 1'b1; if_ready = 1'b1;
    do_reset();
    step(); step();
    imem_ack = 1'b0; redirect = 1'b1; redirect_pc = 32'h103;
    step();
    redirect = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin errors++; $display("FAIL drain_hold1: got %b/%h want 1/8", imem_req, imem_addr); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL drain_flush: got %b want 0", if_valid); end
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin errors++; $display("FAIL drain_hold2: got %b/%h want 1/8", imem_req, imem_addr); end
    step();
    imem_ack = 1'b1;
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || if_valid !== 1'b0) begin
      errors++; $display("FAIL drain_newreq: got %b/%h v%b want 1/100 v0", imem_req, imem_addr, if_valid); end
    step();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_instr !== 32'h40) begin
      errors++; $display("FAIL drain_first: got %b %h/%h want 1 100/40", if_valid, if_pc, if_instr); end
  endtask

  task automatic test_redirect_full();
    imem_ack = 1'b1; if_ready = 1'b0;
    do_reset();
    step(); step();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL full_noreq: got %b want 0", imem_req); end
    if_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
    step();
    redirect = 1'b0;
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL full_flush: got %b want 0", if_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin errors++; $display("FAIL full_newaddr: got %b/%h want 1/40", imem_req, imem_addr); end
    step();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h40 || if_instr !== 32'h10) begin
      errors++; $display("FAIL full_first: got %b %h/%h want 1 40/10", if_valid, if_pc, if_instr); end
  endtask

  task automatic test_halt();
    imem_ack = 1'b0; if_ready = 1'b1;
    do_reset();
    halt = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
    step();
    halt = 1'b0; redirect = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || halted !== 1'b0) begin
      errors++; $display("FAIL halting_hold: got %b/%h h%b want 1/0 h0", imem_req, imem_addr, halted); end
    step();
    checks++; if (halted !== 1'b0 || if_valid !== 1'b0) begin errors++; $display("FAIL halting_wait: got h%b v%b want h0 v0", halted, if_valid); end
    imem_ack = 1'b1;
    step();
    checks++; if (halted !== 1'b1 || imem_req !== 1'b0 || if_valid !== 1'b0) begin
      errors++; $display("FAIL halted: got h%b r%b v%b want h1 r0 v0", halted, imem_req, if_valid); end
    redirect = 1'b1; redirect_pc = 32'h80;
    step();
    redirect = 1'b0; halt = 1'b1;
    step();
    halt = 1'b0;
    step();
    checks++; if (halted !== 1'b1 || imem_req !== 1'b0 || if_valid !== 1'b0) begin
      errors++; $display("FAIL halted_sticky: got h%b r%b v%b want h1 r0 v0", halted, imem_req, if_valid); end
  endtask

  task automatic test_wrap_and_async_reset();
    imem_ack = 1'b1; if_ready = 1'b1;
    do_reset();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    step();
    redirect = 1'b0;
    checks++; if (imem_addr !== 32'hFFFF_FFFC || if_valid !== 1'b0) begin
      errors++; $display("FAIL wrap_target: got %h v%b want fffffffc v0", imem_addr, if_valid); end
    step();
    imem_ack = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr: got %b/%h want 1/0", imem_req, imem_addr); end
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'hFFFF_FFFC || if_instr !== 32'h3FFF_FFFF) begin
      errors++; $display("FAIL wrap_head: got %b %h/%h want 1 fffffffc/3fffffff", if_valid, if_pc, if_instr); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin errors++; $display("FAIL async_req: got %b/%h want 0/0", imem_req, imem_addr); end
    checks++; if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_instr !== 32'h0 || halted !== 1'b0) begin
      errors++; $display("FAIL async_out: got v%b %h/%h h%b want v0 0/0 h0", if_valid, if_pc, if_instr, halted); end
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_drain();
    test_redirect_full();
    test_halt();
    test_wrap_and_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
